// File: rtl/neuron_sequencer_pkg.sv
// Shared types and constants for the SNN layer sequencer (package snn_pkg).
package snn_pkg;

    localparam int unsigned DEF_NUM_INPUTS  = 16;
    localparam int unsigned DEF_NUM_OUTPUTS = 10;
    localparam int unsigned DEF_WEIGHT_SIZE = 8;
    localparam int unsigned DEF_V_MEM_SIZE  = 8;
    localparam int unsigned DEF_B_SIZE      = 8;
    localparam int unsigned DEF_COUNT_WIDTH = 8;

    localparam logic FN_ADD   = 1'b0;
    localparam logic FN_DECAY = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FETCH,
        ACCUM,
        DECAY,
        DONE
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Weight-fetch req/valid bus between the sequencer (master) and weight memory (slave).
interface neuron_sequencer_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;

    modport master (output w_req, w_addr, input  w_valid, w_data);
    modport slave  (input  w_req, w_addr, output w_valid, w_data);
endinterface

// File: rtl/neuron_sequencer_vmem_regfile.sv
// Membrane-potential register file: one combinational read port, one write port, synchronous clear.
module vmem_regfile #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/neuron_sequencer.sv
// Time-step controller for one SNN layer; time-multiplexes an external neuron datapath.
// Optional per-neuron saturating spike counters when SPIKE_COUNT_EN is defined.
module neuron_sequencer
    import snn_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int unsigned NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int unsigned WEIGHT_SIZE = DEF_WEIGHT_SIZE,
    parameter int unsigned V_MEM_SIZE  = DEF_V_MEM_SIZE,
    parameter int unsigned B_SIZE      = DEF_B_SIZE,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start,
    input  logic                   clear_vmem,
    input  logic [NUM_INPUTS-1:0]  in_spikes,
    input  logic [B_SIZE-1:0]      beta,
    input  logic [V_MEM_SIZE-1:0]  v_th,
    neuron_sequencer_if.master     wbus,
    output logic [WEIGHT_SIZE-1:0] n_weight,
    output logic [V_MEM_SIZE-1:0]  n_v_mem_in,
    output logic                   n_function_sel,
    input  logic                   n_spike,
    input  logic [V_MEM_SIZE-1:0]  n_v_mem_out,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_OUTPUTS-1:0] out_spikes
`ifdef SPIKE_COUNT_EN
    ,
    output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] spike_count
`endif
);
    localparam int unsigned IW = clog2_min1(NUM_INPUTS);
    localparam int unsigned JW = clog2_min1(NUM_OUTPUTS);
    localparam int unsigned AW = clog2_min1(NUM_INPUTS * NUM_OUTPUTS);
    localparam logic [IW-1:0] LAST_I = IW'(NUM_INPUTS - 1);
    localparam logic [JW-1:0] LAST_J = JW'(NUM_OUTPUTS - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic [JW-1:0]          j_q, j_d;
    logic [WEIGHT_SIZE-1:0] wt_q, wt_d;
    logic [NUM_INPUTS-1:0]  spk_q, spk_d;
    logic [NUM_OUTPUTS-1:0] out_q, out_d;

    logic                  vm_we, vm_clr;
    logic [V_MEM_SIZE-1:0] vm_rdata;

    // beta and v_th are wired to the neuron at layer level; they only pass by this block.
    logic unused_fwd;
    assign unused_fwd = ^{beta, v_th};

`ifdef SPIKE_COUNT_EN
    logic [NUM_OUTPUTS-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;
    assign spike_count = cnt_q;
`else
    logic [COUNT_WIDTH-1:0] unused_cw;
    assign unused_cw = '0;
`endif

    vmem_regfile #(
        .DEPTH (NUM_OUTPUTS),
        .WIDTH (V_MEM_SIZE),
        .AW    (JW)
    ) u_vmem (
        .clk_i   (wb_clk_i),
        .clr_i   (vm_clr),
        .we_i    (vm_we),
        .waddr_i (j_q),
        .wdata_i (n_v_mem_out),
        .raddr_i (j_q),
        .rdata_o (vm_rdata)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            wt_q    <= '0;
            spk_q   <= '0;
            out_q   <= '0;
`ifdef SPIKE_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            wt_q    <= wt_d;
            spk_q   <= spk_d;
            out_q   <= out_d;
`ifdef SPIKE_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        j_d            = j_q;
        wt_d           = wt_q;
        spk_d          = spk_q;
        out_d          = out_q;
        vm_we          = 1'b0;
        vm_clr         = wb_rst_i;
        wbus.w_req     = 1'b0;
        wbus.w_addr    = '0;
        n_weight       = '0;
        n_v_mem_in     = '0;
        n_function_sel = FN_ADD;
`ifdef SPIKE_COUNT_EN
        cnt_d          = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (clear_vmem) begin
                    vm_clr = 1'b1;
`ifdef SPIKE_COUNT_EN
                    cnt_d  = '0;
`endif
                end
                if (start) begin
                    spk_d   = in_spikes;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = SCAN;
                end
            end
            // The last index is resolved by lookahead so no cycle is spent past it.
            SCAN: begin
                if (spk_q[i_q]) begin
                    j_d     = '0;
                    state_d = FETCH;
                end else if (i_q == LAST_I) begin
                    j_d     = '0;
                    state_d = DECAY;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            FETCH: begin
                wbus.w_req  = 1'b1;
                wbus.w_addr = AW'(i_q) * AW'(NUM_OUTPUTS) + AW'(j_q);
                if (wbus.w_valid) begin
                    wt_d    = wbus.w_data;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                n_function_sel = FN_ADD;
                n_v_mem_in     = vm_rdata;
                n_weight       = wt_q;
                vm_we          = 1'b1;
                if (j_q == LAST_J) begin
                    j_d = '0;
                    if (i_q == LAST_I) begin
                        state_d = DECAY;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = SCAN;
                    end
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DECAY: begin
                n_function_sel = FN_DECAY;
                n_v_mem_in     = vm_rdata;
                vm_we          = 1'b1;
                out_d[j_q]     = n_spike;
`ifdef SPIKE_COUNT_EN
                if (n_spike && (cnt_q[j_q] != '1)) begin
                    cnt_d[j_q] = cnt_q[j_q] + 1'b1;
                end
`endif
                if (j_q == LAST_J) begin
                    j_d     = '0;
                    state_d = DONE;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign out_spikes = out_q;
endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a behavioural neuron and weight memory (weights = 6).
// Covers SPIKE_COUNT_EN checks when that macro is defined for the build.
module tb_neuron_sequencer;
    localparam int unsigned NI = 4;
    localparam int unsigned NO = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, clear_vmem;
    logic [3:0] in_spikes;
    logic [7:0] beta, v_th;
    logic [7:0] n_weight, n_v_mem_in, n_v_mem_out;
    logic       n_function_sel, n_spike;
    logic       busy, done;
    logic [1:0] out_spikes;
`ifdef SPIKE_COUNT_EN
    logic [15:0] spike_count;
`endif

    neuron_sequencer_if #(.ADDR_W(3), .DATA_W(8)) wif ();

    neuron_sequencer #(
        .NUM_INPUTS  (NI),
        .NUM_OUTPUTS (NO),
        .WEIGHT_SIZE (8),
        .V_MEM_SIZE  (8),
        .B_SIZE      (8),
        .COUNT_WIDTH (8)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .start          (start),
        .clear_vmem     (clear_vmem),
        .in_spikes      (in_spikes),
        .beta           (beta),
        .v_th           (v_th),
        .wbus           (wif),
        .n_weight       (n_weight),
        .n_v_mem_in     (n_v_mem_in),
        .n_function_sel (n_function_sel),
        .n_spike        (n_spike),
        .n_v_mem_out    (n_v_mem_out),
        .busy           (busy),
        .done           (done),
        .out_spikes     (out_spikes)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_count    (spike_count)
`endif
    );

    always #5 clk = ~clk;

    // Neuron: add weight, or multiply by beta and fire (reset to 0) above threshold.
    logic [15:0] prod;
    always_comb begin
        prod        = {8'd0, n_v_mem_in} * {8'd0, beta};
        n_spike     = 1'b0;
        n_v_mem_out = n_v_mem_in + n_weight;
        if (n_function_sel) begin
            n_spike     = (prod[7:0] > v_th);
            n_v_mem_out = n_spike ? 8'd0 : prod[7:0];
        end
    end

    // Weight memory with programmable wait states and an always-valid override.
    int   wait_cycles = 0;
    logic force_v = 1'b0;
    int   wcnt = 0;
    assign wif.w_data  = 8'd6;
    assign wif.w_valid = force_v | (wif.w_req && (wcnt >= wait_cycles));

    int       wreq_n = 0, n_log = 0, stab_bad = 0, done_n = 0;
    logic [2:0] addr_log [0:63];
    logic     prev_req = 1'b0, prev_val = 1'b0;
    logic [2:0] prev_addr = '0;
    always @(posedge clk) begin
        wcnt <= (wif.w_req && !wif.w_valid) ? wcnt + 1 : 0;
        if (wif.w_req) wreq_n <= wreq_n + 1;
        if (wif.w_req && wif.w_valid) begin
            addr_log[n_log[5:0]] <= wif.w_addr;
            n_log <= n_log + 1;
        end
        if (wif.w_req && prev_req && !prev_val && (wif.w_addr != prev_addr))
            stab_bad <= stab_bad + 1;
        if (done) done_n <= done_n + 1;
        prev_req  <= wif.w_req;
        prev_val  <= wif.w_valid;
        prev_addr <= wif.w_addr;
    end

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_step(input logic [3:0] spk, input logic clr, output int cyc);
        in_spikes  = spk;
        start      = 1'b1;
        clear_vmem = clr;
        tick();
        start      = 1'b0;
        clear_vmem = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic pulse_clear();
        clear_vmem = 1'b1;
        tick();
        clear_vmem = 1'b0;
    endtask

    int cyc, w0, l0, s0, d0;

    initial begin
        rst = 1'b1; start = 1'b0; clear_vmem = 1'b0; in_spikes = '0;
        beta = 8'd1; v_th = 8'd10;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", {30'd0, out_spikes}, 32'd0);
        check("rst_wreq", {31'd0, wif.w_req}, 32'd0);
        check("rst_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd0);
        check("rst_vmem1", {24'd0, dut.u_vmem.mem_q[1]}, 32'd0);

        // Case 1: two input spikes, both neurons reach 12 and fire.
        w0 = wreq_n;
        run_step(4'b0011, 1'b0, cyc);
        check("c1_latency", cyc, 15);
        check("c1_out", {30'd0, out_spikes}, 32'd3);
        check("c1_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd0);
        check("c1_vmem1", {24'd0, dut.u_vmem.mem_q[1]}, 32'd0);
        check("c1_wreq_cycles", wreq_n - w0, 4);

        // Case 2: sub-threshold, then a repeat crosses threshold.
        run_step(4'b0001, 1'b0, cyc);
        check("c2a_latency", cyc, 11);
        check("c2a_out", {30'd0, out_spikes}, 32'd0);
        check("c2a_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd6);
        check("c2a_vmem1", {24'd0, dut.u_vmem.mem_q[1]}, 32'd6);
        run_step(4'b0001, 1'b0, cyc);
        check("c2b_out", {30'd0, out_spikes}, 32'd3);
        check("c2b_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd0);

        // Case 3: empty spike vector.
        w0 = wreq_n;
        run_step(4'b0000, 1'b0, cyc);
        check("c3_latency", cyc, 7);
        check("c3_wreq_cycles", wreq_n - w0, 0);
        check("c3_out", {30'd0, out_spikes}, 32'd0);

        // Case 4: three wait states per weight.
        wait_cycles = 3;
        w0 = wreq_n; l0 = n_log; s0 = stab_bad;
        run_step(4'b0011, 1'b0, cyc);
        wait_cycles = 0;
        check("c4_latency", cyc, 27);
        check("c4_wreq_cycles", wreq_n - w0, 16);
        check("c4_n_fetch", n_log - l0, 4);
        for (int k = 0; k < 4; k++)
            check("c4_addr", {29'd0, addr_log[l0 + k]}, k);
        check("c4_addr_stable", stab_bad - s0, 0);
        check("c4_out", {30'd0, out_spikes}, 32'd3);
        check("c4_vmem1", {24'd0, dut.u_vmem.mem_q[1]}, 32'd0);

        // clear_vmem leaves out_spikes alone; start+clear clears before accumulating.
        pulse_clear();
        check("clr_keeps_out", {30'd0, out_spikes}, 32'd3);
        run_step(4'b0001, 1'b0, cyc);
        check("pre_clr_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd6);
        run_step(4'b0001, 1'b1, cyc);
        check("start_clr_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd6);
        check("start_clr_out", {30'd0, out_spikes}, 32'd0);
        pulse_clear();
        check("clr_vmem1", {24'd0, dut.u_vmem.mem_q[1]}, 32'd0);
        run_step(4'b0001, 1'b0, cyc);

        // Case 5a: reset while in FETCH aborts the step.
        wait_cycles = 5;
        d0 = done_n;
        in_spikes = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!wif.w_req && cyc < 50) begin
            tick();
            cyc++;
        end
        check("c5_reached_fetch", {31'd0, wif.w_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_cycles = 0;
        check("c5_rst_busy", {31'd0, busy}, 32'd0);
        check("c5_rst_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd0);
        check("c5_rst_vmem1", {24'd0, dut.u_vmem.mem_q[1]}, 32'd0);
        repeat (20) tick();
        check("c5_no_done", done_n - d0, 0);
        check("c5_idle_busy", {31'd0, busy}, 32'd0);

        // Case 5b: start while busy is ignored.
        d0 = done_n;
        in_spikes = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        repeat (2) begin
            tick();
            cyc++;
        end
        check("c5b_busy", {31'd0, busy}, 32'd1);
        in_spikes = 4'b1111;
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        check("c5b_latency", cyc, 11);
        repeat (20) tick();
        check("c5b_one_done", done_n - d0, 1);
        check("c5b_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd6);
        check("c5b_out", {30'd0, out_spikes}, 32'd0);

        // w_valid held high outside FETCH must not be consumed.
        force_v = 1'b1;
        repeat (3) tick();
        run_step(4'b0011, 1'b0, cyc);
        force_v = 1'b0;
        check("fv_latency", cyc, 15);
        check("fv_out", {30'd0, out_spikes}, 32'd3);
        check("fv_vmem0", {24'd0, dut.u_vmem.mem_q[0]}, 32'd0);

`ifdef SPIKE_COUNT_EN
        pulse_clear();
        check("c6_cnt_cleared", {16'd0, spike_count}, 32'd0);
        repeat (3) run_step(4'b0011, 1'b0, cyc);
        check("c6_cnt_three", {16'd0, spike_count}, 32'h0303);
        pulse_clear();
        check("c6_cnt_clr", {16'd0, spike_count}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
